neureka_infeat_buffer_sequencer: RTL
====================================

// Module: neureka_infeat_buffer_sequencer
// PURPOSE
//  Sequences the input-feature buffer for one spatial tile: accepts a tile command, drives the buffer's
//  goto_load/goto_extract/goto_idle strobes, and generates its per-word implicit/explicit padding masks
//  and load length. Holds the buffer in EXTRACT for a programmed number of consumer beats, then releases it.
//  Sits between the main engine controller and the buffer; observes the buffer via its state flag.
// PARAMETERS
//  BUF_W   8   buffer side in pixels; NW = BUF_W*BUF_W words, AW = $clog2(NW)
//  PE_W    6   PE array side; the active region in 1x1 mode is PE_W x PE_W
//  CNT_W   8   width of extract-beat counter
// PORTS
//  clk_i              in   1      clock
//  rst_ni             in   1      asynchronous active-low reset
//  enable_i           in   1      low: freeze all state, counters and outputs (strobes forced 0)
//  clear_i            in   1      synchronous clear to reset state (wins over enable_i)
//  cmd_valid_i        in   1      tile command valid
//  cmd_ready_o        out  1      tile command accepted when valid&ready
//  cmd_filter_1x1_i   in   1      1: 1x1 mode, 0: 3x3 mode
//  cmd_reuse_i        in   1      1: skip load, re-extract current contents
//  cmd_tile_h_i       in   AW/2+1 valid rows in tile (1..BUF_W)
//  cmd_tile_w_i       in   AW/2+1 valid cols in tile (1..BUF_W)
//  cmd_pad_i          in   4      explicit pad {top,bottom,left,right}, 1 pixel each, 3x3 mode only
//  cmd_n_extract_i    in   CNT_W  number of extract beats
//  ib_state_i         in   2      buffer state: 0 IDLE, 1 LOAD, 2 EXTRACT
//  goto_load_o        out  1      buffer strobe
//  goto_extract_o     out  1      buffer strobe
//  goto_idle_o        out  1      buffer strobe
//  load_len_o         out  AW+1   words to load; constant NW
//  implicit_pad_o     out  NW     per-word zero-pad mask
//  explicit_pad_o     out  NW     per-word explicit-pad mask
//  filter_1x1_o       out  1      latched filter mode
//  extract_valid_o    out  1      buffer contents valid for consumer
//  extract_ready_i    in   1      consumer takes one beat
//  done_o             out  1      one-cycle pulse: tile finished, buffer back in IDLE
// BEHAVIOUR
//  Reset/clear: state S_IDLE; masks, filter_1x1_o, beat counter = 0; all strobes, extract_valid_o, done_o = 0.
//  cmd_ready_o = (state==S_IDLE) & enable_i & ~clear_i (combinational, so 1 after reset when enabled).
//  Accept (S_IDLE, valid&ready): latch mode, masks, n_extract; next state S_LOAD, or S_REUSE if cmd_reuse_i.
//  Masks, word p = r*BUF_W + c, computed from the command and registered on accept (stable until done_o):
//   H = 1x1 ? min(tile_h,PE_W) : tile_h; W likewise; implicit[p] = (r>=H) | (c>=W).
//   explicit[p] (3x3 only, else 0) = (top&r==0)|(bottom&r==BUF_W-1)|(left&c==0)|(right&c==BUF_W-1), & ~implicit[p].
//  S_LOAD: goto_load_o=1 while ib_state_i==IDLE; when ib_state_i==EXTRACT -> S_EXTRACT (or S_RELEASE if n_extract==0).
//  S_REUSE: goto_extract_o=1 while ib_state_i==IDLE; on EXTRACT -> same transition as S_LOAD.
//  S_EXTRACT: extract_valid_o=1; count on valid&ready; on the beat making count==n_extract -> S_RELEASE, count cleared.
//  S_RELEASE: goto_idle_o=1 while ib_state_i==EXTRACT; when ib_state_i==IDLE: done_o=1 that cycle, -> S_IDLE.
//  Strobes are level-held until the buffer state acknowledges; at most one strobe high in any cycle.
//  extract_valid_o never drops without a completed beat except on clear_i/reset.
//  enable_i low mid-operation: pause in place, resume identically; clear_i mid-operation: abort, no done_o.
//  Unexpected ib_state_i (3, or LOAD seen in S_REUSE/S_RELEASE): hold state, no strobe, wait.
//  Counter width CNT_W; n_extract = 2^CNT_W-1 must complete without wrap.
// TESTING
//  3x3, tile 8x8, pad 0, n_extract 4, buffer model: goto_load 1 cycle, LOAD 64 cycles -> 4 beats, done_o once, masks all 0.
//  3x3, tile 5x7, pad {1,0,1,0} -> implicit set for r>=5 or c>=7; explicit for r==0 or c==0 only where not implicit.
//  1x1, tile 8x8 -> implicit set for r>=6 or c>=6 (28 words), explicit all 0, filter_1x1_o=1.
//  reuse=1, n_extract 2, buffer in IDLE -> goto_extract_o, never goto_load_o; 2 beats; done_o.
//  n_extract=0 -> S_LOAD then direct S_RELEASE, extract_valid_o never high, done_o after IDLE.
//  clear_i during S_EXTRACT after 1 of 3 beats -> next cycle cmd_ready_o=1, masks 0, no done_o; enable_i low 10 cycles in S_LOAD -> strobes 0, resumes.

Source files
------------

// File: rtl/neureka_infeat_buffer_sequencer_if.sv
`timescale 1ns/1ps
// Command, buffer-control and consumer signals shared between the engine controller,
// the input-feature buffer sequencer and the buffer it drives.
interface neureka_infeat_buffer_sequencer_if #(
    parameter int BUF_W = 8,
    parameter int CNT_W = 8
);
    localparam int NW = BUF_W * BUF_W;
    localparam int AW = $clog2(NW);

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_filter_1x1_i;
    logic              cmd_reuse_i;
    logic [AW/2:0]     cmd_tile_h_i;
    logic [AW/2:0]     cmd_tile_w_i;
    logic [3:0]        cmd_pad_i;
    logic [CNT_W-1:0]  cmd_n_extract_i;
    logic [1:0]        ib_state_i;
    logic              goto_load_o;
    logic              goto_extract_o;
    logic              goto_idle_o;
    logic [AW:0]       load_len_o;
    logic [NW-1:0]     implicit_pad_o;
    logic [NW-1:0]     explicit_pad_o;
    logic              filter_1x1_o;
    logic              extract_valid_o;
    logic              extract_ready_i;
    logic              done_o;

    modport master (
        output cmd_valid_i, cmd_filter_1x1_i, cmd_reuse_i, cmd_tile_h_i, cmd_tile_w_i,
        output cmd_pad_i, cmd_n_extract_i, ib_state_i, extract_ready_i,
        input  cmd_ready_o, goto_load_o, goto_extract_o, goto_idle_o, load_len_o,
        input  implicit_pad_o, explicit_pad_o, filter_1x1_o, extract_valid_o, done_o
    );

    modport slave (
        input  cmd_valid_i, cmd_filter_1x1_i, cmd_reuse_i, cmd_tile_h_i, cmd_tile_w_i,
        input  cmd_pad_i, cmd_n_extract_i, ib_state_i, extract_ready_i,
        output cmd_ready_o, goto_load_o, goto_extract_o, goto_idle_o, load_len_o,
        output implicit_pad_o, explicit_pad_o, filter_1x1_o, extract_valid_o, done_o
    );
endinterface

// File: rtl/neureka_infeat_buffer_sequencer.sv
`timescale 1ns/1ps
// Walks the input-feature buffer through load/extract/idle for one tile and supplies
// the per-word padding masks and load length that go with that tile.
module neureka_infeat_buffer_sequencer #(
    parameter int BUF_W = 8,
    parameter int PE_W  = 6,
    parameter int CNT_W = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic clear_i,
    neureka_infeat_buffer_sequencer_if.slave bus
);
    localparam int NW = BUF_W * BUF_W;
    localparam int AW = $clog2(NW);
    localparam int HW = AW / 2 + 1;
    localparam logic [1:0] IB_IDLE    = 2'd0;
    localparam logic [1:0] IB_EXTRACT = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REUSE, S_EXTRACT, S_RELEASE} state_e;

    state_e           r_state, w_state_next;
    logic [NW-1:0]    r_implicit, r_explicit, w_implicit, w_explicit;
    logic             r_filter_1x1;
    logic [CNT_W-1:0] r_n_extract, r_count, w_count_inc;
    logic [HW-1:0]    w_rows, w_cols;
    logic             w_accept, w_beat, w_last_beat, w_ready, w_valid, w_done;
    logic             w_goto_load, w_goto_extract, w_goto_idle;

    // In 1x1 mode only the PE_W x PE_W corner of the tile feeds the array.
    assign w_rows = (bus.cmd_filter_1x1_i && (bus.cmd_tile_h_i > HW'(PE_W))) ? HW'(PE_W) : bus.cmd_tile_h_i;
    assign w_cols = (bus.cmd_filter_1x1_i && (bus.cmd_tile_w_i > HW'(PE_W))) ? HW'(PE_W) : bus.cmd_tile_w_i;

    always_comb begin
        w_implicit = '0;
        w_explicit = '0;
        for (int r = 0; r < BUF_W; r++) begin
            for (int c = 0; c < BUF_W; c++) begin
                w_implicit[AW'(r * BUF_W + c)] = (HW'(r) >= w_rows) || (HW'(c) >= w_cols);
                w_explicit[AW'(r * BUF_W + c)] = !bus.cmd_filter_1x1_i && !w_implicit[AW'(r * BUF_W + c)] &&
                    ((bus.cmd_pad_i[3] && (r == 0)) || (bus.cmd_pad_i[2] && (r == BUF_W - 1)) ||
                     (bus.cmd_pad_i[1] && (c == 0)) || (bus.cmd_pad_i[0] && (c == BUF_W - 1)));
            end
        end
    end

    assign w_count_inc = r_count + 1'b1;
    assign w_last_beat = (w_count_inc == r_n_extract);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else if (clear_i) begin
            r_state <= S_IDLE;
        end else if (enable_i) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_beat         = 1'b0;
        w_ready        = 1'b0;
        w_valid        = 1'b0;
        w_done         = 1'b0;
        w_goto_load    = 1'b0;
        w_goto_extract = 1'b0;
        w_goto_idle    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.cmd_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = bus.cmd_reuse_i ? S_REUSE : S_LOAD;
                end
            end
            S_LOAD, S_REUSE: begin
                // Any buffer state other than IDLE/EXTRACT here just means wait.
                w_goto_load    = (r_state == S_LOAD)  && (bus.ib_state_i == IB_IDLE);
                w_goto_extract = (r_state == S_REUSE) && (bus.ib_state_i == IB_IDLE);
                if (bus.ib_state_i == IB_EXTRACT) begin
                    w_state_next = (r_n_extract == '0) ? S_RELEASE : S_EXTRACT;
                end
            end
            S_EXTRACT: begin
                w_valid = 1'b1;
                if (bus.extract_ready_i) begin
                    w_beat = 1'b1;
                    if (w_last_beat) begin
                        w_state_next = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                w_goto_idle = (bus.ib_state_i == IB_EXTRACT);
                if (bus.ib_state_i == IB_IDLE) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_implicit   <= '0;
            r_explicit   <= '0;
            r_filter_1x1 <= 1'b0;
            r_n_extract  <= '0;
            r_count      <= '0;
        end else if (clear_i) begin
            r_implicit   <= '0;
            r_explicit   <= '0;
            r_filter_1x1 <= 1'b0;
            r_n_extract  <= '0;
            r_count      <= '0;
        end else if (enable_i) begin
            if (w_accept) begin
                r_implicit   <= w_implicit;
                r_explicit   <= w_explicit;
                r_filter_1x1 <= bus.cmd_filter_1x1_i;
                r_n_extract  <= bus.cmd_n_extract_i;
                r_count      <= '0;
            end
            if (w_beat) begin
                r_count <= w_last_beat ? '0 : w_count_inc;
            end
        end
    end

    // Valid is deliberately not gated by enable so the consumer never sees it retracted mid-beat.
    assign bus.cmd_ready_o     = w_ready && enable_i && !clear_i;
    assign bus.goto_load_o     = w_goto_load && enable_i;
    assign bus.goto_extract_o  = w_goto_extract && enable_i;
    assign bus.goto_idle_o     = w_goto_idle && enable_i;
    assign bus.done_o          = w_done && enable_i && !clear_i;
    assign bus.extract_valid_o = w_valid;
    assign bus.load_len_o      = (AW + 1)'(NW);
    assign bus.implicit_pad_o  = r_implicit;
    assign bus.explicit_pad_o  = r_explicit;
    assign bus.filter_1x1_o    = r_filter_1x1;
endmodule
